butterfly_dit_seq: RTL and testbench

Sequential radix-2 decimation-in-time butterfly for the inverse/forward transform back end: computes Xa = xa + W·xb, Xb = xa − W·xb with a single time-shared 16×16 multiplier. It is the DIT counterpart of the pipelined DIF butterfly: multiply first, then add/subtract. It sits between the twiddle ROM / data RAM read port and the write-back path, with valid/ready handshakes on both sides. Optional twiddle conjugation and output halving support IFFT passes.

---
 rtl/butterfly_dit_seq_if.sv | 30 +++
 rtl/butterfly_dit_seq.sv | 167 ++++++++++++++++
 tb/tb_butterfly_dit_seq.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/butterfly_dit_seq_if.sv
// Operand/result handshake bundle for the sequential DIT butterfly.
interface butterfly_dit_seq_if;
    localparam int unsigned DW = 16;

    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] xa_re;
    logic signed [DW-1:0] xa_im;
    logic signed [DW-1:0] xb_re;
    logic signed [DW-1:0] xb_im;
    logic signed [DW-1:0] W_re;
    logic signed [DW-1:0] W_im;

    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] Xa_re;
    logic signed [DW-1:0] Xa_im;
    logic signed [DW-1:0] Xb_re;
    logic signed [DW-1:0] Xb_im;

    modport master (
        output in_valid, xa_re, xa_im, xb_re, xb_im, W_re, W_im, out_ready,
        input  in_ready, out_valid, Xa_re, Xa_im, Xb_re, Xb_im
    );

    modport slave (
        input  in_valid, xa_re, xa_im, xb_re, xb_im, W_re, W_im, out_ready,
        output in_ready, out_valid, Xa_re, Xa_im, Xb_re, Xb_im
    );
endinterface

// File: rtl/butterfly_dit_seq.sv
// Sequential radix-2 DIT butterfly: Xa = xa + W*xb, Xb = xa - W*xb using one
// time-shared 16x16 multiplier (four products, then one add/subtract cycle).
module butterfly_dit_seq #(
    parameter bit INVERSE = 1'b0,
    parameter bit SCALE   = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    butterfly_dit_seq_if.slave bus
);
    localparam int unsigned DW = 16;
    localparam int unsigned EW = DW + 1;
    localparam int unsigned PW = 2 * DW;

    localparam logic signed [EW-1:0] POS_LIM = 17'sd32767;
    localparam logic signed [EW-1:0] NEG_LIM = -17'sd32767;
    localparam logic signed [DW-1:0] SAT_HI  = 16'sd32767;
    localparam logic signed [DW-1:0] SAT_LO  = -16'sd32767;

    typedef enum logic [2:0] {IDLE, MUL0, MUL1, MUL2, MUL3, SUM, OUT} state_t;

    state_t state;
    state_t state_nxt;

    logic accept;
    logic out_take;
    logic load_out;

    logic signed [DW-1:0] xa_re_q, xa_im_q, xb_re_q, xb_im_q, w_re_q, w_im_q;
    logic signed [DW-1:0] p0, p1, p2, p3;
    logic signed [DW-1:0] mul_a, mul_b, mul_hi, wi_in;
    logic signed [PW-1:0] mul_prod;
    logic signed [DW-1:0] t_re, t_im, ra_re, ra_im, rb_re, rb_im;

    // Symmetric saturation of a 17-bit intermediate to 16 bits (-32767..32767).
    function automatic logic signed [DW-1:0] sat(input logic signed [EW-1:0] v);
        if (v > POS_LIM) begin
            return SAT_HI;
        end else if (v < NEG_LIM) begin
            return SAT_LO;
        end else begin
            return DW'(v);
        end
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: four multiply cycles, one sum cycle, then hold in OUT.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.in_valid) state_nxt = MUL0;
            MUL0: state_nxt = MUL1;
            MUL1: state_nxt = MUL2;
            MUL2: state_nxt = MUL3;
            MUL3: state_nxt = SUM;
            SUM:  state_nxt = OUT;
            OUT:  if (bus.out_ready) state_nxt = bus.in_valid ? MUL0 : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: handshake and datapath load strobes.
    always_comb begin
        bus.in_ready = 1'b0;
        out_take     = 1'b0;
        load_out     = 1'b0;
        case (state)
            IDLE: bus.in_ready = 1'b1;
            SUM:  load_out     = 1'b1;
            OUT: begin
                bus.in_ready = bus.out_ready;
                out_take     = bus.out_ready;
            end
            default: ;
        endcase
        accept = bus.in_ready & bus.in_valid;
    end

    // Conjugated twiddle imaginary part, resolved once at capture time.
    always_comb begin
        wi_in = INVERSE ? sat(-EW'(bus.W_im)) : bus.W_im;
    end

    // Multiplier operand selection per multiply cycle; keep product bits [31:16].
    always_comb begin
        mul_a = xb_re_q;
        mul_b = w_re_q;
        case (state)
            MUL1: begin mul_a = xb_im_q; mul_b = w_im_q; end
            MUL2: begin mul_a = xb_re_q; mul_b = w_im_q; end
            MUL3: begin mul_a = xb_im_q; mul_b = w_re_q; end
            default: ;
        endcase
        mul_prod = PW'(mul_a) * PW'(mul_b);
        mul_hi   = DW'(mul_prod >>> DW);
    end

    // Complex twiddle product, add/subtract against xa, optional halving.
    always_comb begin
        t_re  = sat(EW'(p0) - EW'(p1));
        t_im  = sat(EW'(p2) + EW'(p3));
        ra_re = sat(EW'(xa_re_q) + EW'(t_re));
        ra_im = sat(EW'(xa_im_q) + EW'(t_im));
        rb_re = sat(EW'(xa_re_q) - EW'(t_re));
        rb_im = sat(EW'(xa_im_q) - EW'(t_im));
        if (SCALE) begin
            ra_re = ra_re >>> 1;
            ra_im = ra_im >>> 1;
            rb_re = rb_re >>> 1;
            rb_im = rb_im >>> 1;
        end
    end

    // Operand capture, product registers and registered results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xa_re_q       <= '0;
            xa_im_q       <= '0;
            xb_re_q       <= '0;
            xb_im_q       <= '0;
            w_re_q        <= '0;
            w_im_q        <= '0;
            p0            <= '0;
            p1            <= '0;
            p2            <= '0;
            p3            <= '0;
            bus.out_valid <= 1'b0;
            bus.Xa_re     <= '0;
            bus.Xa_im     <= '0;
            bus.Xb_re     <= '0;
            bus.Xb_im     <= '0;
        end else begin
            if (accept) begin
                xa_re_q <= bus.xa_re;
                xa_im_q <= bus.xa_im;
                xb_re_q <= bus.xb_re;
                xb_im_q <= bus.xb_im;
                w_re_q  <= bus.W_re;
                w_im_q  <= wi_in;
            end
            case (state)
                MUL0: p0 <= mul_hi;
                MUL1: p1 <= mul_hi;
                MUL2: p2 <= mul_hi;
                MUL3: p3 <= mul_hi;
                default: ;
            endcase
            if (load_out) begin
                bus.Xa_re     <= ra_re;
                bus.Xa_im     <= ra_im;
                bus.Xb_re     <= rb_re;
                bus.Xb_im     <= rb_im;
                bus.out_valid <= 1'b1;
            end else if (out_take) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_butterfly_dit_seq.sv
// Directed bench for butterfly_dit_seq: three instances (plain, inverse,
// scaled) share one stimulus stream so each feature is checked side by side.
module tb_butterfly_dit_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic signed [15:0] xa_re = '0, xa_im = '0, xb_re = '0, xb_im = '0;
    logic signed [15:0] w_re = '0, w_im = '0;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    butterfly_dit_seq_if u0_if ();
    butterfly_dit_seq_if u1_if ();
    butterfly_dit_seq_if u2_if ();

    assign u0_if.in_valid = in_valid;  assign u0_if.out_ready = out_ready;
    assign u0_if.xa_re = xa_re;  assign u0_if.xa_im = xa_im;
    assign u0_if.xb_re = xb_re;  assign u0_if.xb_im = xb_im;
    assign u0_if.W_re = w_re;    assign u0_if.W_im = w_im;
    assign u1_if.in_valid = in_valid;  assign u1_if.out_ready = out_ready;
    assign u1_if.xa_re = xa_re;  assign u1_if.xa_im = xa_im;
    assign u1_if.xb_re = xb_re;  assign u1_if.xb_im = xb_im;
    assign u1_if.W_re = w_re;    assign u1_if.W_im = w_im;
    assign u2_if.in_valid = in_valid;  assign u2_if.out_ready = out_ready;
    assign u2_if.xa_re = xa_re;  assign u2_if.xa_im = xa_im;
    assign u2_if.xb_re = xb_re;  assign u2_if.xb_im = xb_im;
    assign u2_if.W_re = w_re;    assign u2_if.W_im = w_im;

    butterfly_dit_seq #(.INVERSE(1'b0), .SCALE(1'b0)) u_plain (.clk(clk), .rst_n(rst_n), .bus(u0_if));
    butterfly_dit_seq #(.INVERSE(1'b1), .SCALE(1'b0)) u_inv   (.clk(clk), .rst_n(rst_n), .bus(u1_if));
    butterfly_dit_seq #(.INVERSE(1'b0), .SCALE(1'b1)) u_scale (.clk(clk), .rst_n(rst_n), .bus(u2_if));

    // Present one operand set from IDLE, accept it, count edges until out_valid.
    task automatic do_op(input logic signed [15:0] ar, ai, br, bi, wr, wi, output int lat);
        xa_re = ar; xa_im = ai; xb_re = br; xb_im = bi; w_re = wr; w_im = wi;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (u0_if.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Hand the result downstream for one cycle.
    task automatic take();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (u0_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", u0_if.in_ready); end
        n_checks++;
        if (u0_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", u0_if.out_valid); end
        n_checks++;
        if (u0_if.Xa_re !== 16'sd0 || u0_if.Xb_im !== 16'sd0) begin
            n_fail++; $display("FAIL reset_outputs: got Xa_re=%0d Xb_im=%0d expected 0", u0_if.Xa_re, u0_if.Xb_im);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat;
        do_op(16'sd4096, 16'sd0, 16'sd16384, 16'sd0, 16'sd32767, 16'sd0, lat);
        n_checks++;
        if (lat != 5) begin n_fail++; $display("FAIL basic_latency: got %0d expected 5", lat); end
        n_checks++;
        if (u0_if.Xa_re !== 16'sd12287) begin n_fail++; $display("FAIL basic_xa_re: got %0d expected 12287", u0_if.Xa_re); end
        n_checks++;
        if (u0_if.Xb_re !== -16'sd4095) begin n_fail++; $display("FAIL basic_xb_re: got %0d expected -4095", u0_if.Xb_re); end
        n_checks++;
        if (u0_if.Xa_im !== 16'sd0 || u0_if.Xb_im !== 16'sd0) begin
            n_fail++; $display("FAIL basic_imag: got %0d/%0d expected 0/0", u0_if.Xa_im, u0_if.Xb_im);
        end
        n_checks++;
        if (u2_if.Xa_re !== 16'sd6143) begin n_fail++; $display("FAIL scale_xa_re: got %0d expected 6143", u2_if.Xa_re); end
        n_checks++;
        if (u2_if.Xb_re !== -16'sd2048) begin n_fail++; $display("FAIL scale_xb_re: got %0d expected -2048", u2_if.Xb_re); end
        n_checks++;
        if (u0_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL out_in_ready: got %b expected 0", u0_if.in_ready); end
        take();
        n_checks++;
        if (u0_if.out_valid !== 1'b0 || u0_if.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL after_take: got out_valid=%b in_ready=%b expected 0/1", u0_if.out_valid, u0_if.in_ready);
        end
    endtask

    task automatic test_imag();
        int lat;
        do_op(16'sd0, 16'sd4096, 16'sd0, 16'sd16384, 16'sd32767, 16'sd0, lat);
        n_checks++;
        if (u0_if.Xa_im !== 16'sd12287 || u0_if.Xb_im !== -16'sd4095) begin
            n_fail++; $display("FAIL imag_path: got Xa_im=%0d Xb_im=%0d expected 12287/-4095", u0_if.Xa_im, u0_if.Xb_im);
        end
        n_checks++;
        if (u0_if.Xa_re !== 16'sd0 || u0_if.Xb_re !== 16'sd0) begin
            n_fail++; $display("FAIL imag_real_zero: got %0d/%0d expected 0/0", u0_if.Xa_re, u0_if.Xb_re);
        end
        take();
    endtask

    task automatic test_saturation();
        int lat;
        do_op(16'sd28672, 16'sd0, 16'sd32767, 16'sd0, 16'sd32767, 16'sd0, lat);
        n_checks++;
        if (u0_if.Xa_re !== 16'sd32767) begin n_fail++; $display("FAIL sat_pos_xa: got %0d expected 32767", u0_if.Xa_re); end
        n_checks++;
        if (u0_if.Xb_re !== 16'sd12289) begin n_fail++; $display("FAIL sat_pos_xb: got %0d expected 12289", u0_if.Xb_re); end
        take();
        do_op(-16'sd28672, 16'sd0, -16'sd32767, 16'sd0, 16'sd32767, 16'sd0, lat);
        n_checks++;
        if (u0_if.Xa_re !== -16'sd32767) begin n_fail++; $display("FAIL sat_neg_xa: got %0d expected -32767", u0_if.Xa_re); end
        n_checks++;
        if (u0_if.Xb_re !== -16'sd12288) begin n_fail++; $display("FAIL sat_neg_xb: got %0d expected -12288", u0_if.Xb_re); end
        take();
    endtask

    task automatic test_conjugate();
        int lat;
        do_op(16'sd0, 16'sd0, 16'sd0, 16'sd16384, 16'sd0, 16'sd16384, lat);
        n_checks++;
        if (u0_if.Xa_re !== -16'sd4096 || u0_if.Xb_re !== 16'sd4096) begin
            n_fail++; $display("FAIL conj_fwd: got %0d/%0d expected -4096/4096", u0_if.Xa_re, u0_if.Xb_re);
        end
        n_checks++;
        if (u1_if.Xa_re !== 16'sd4096 || u1_if.Xb_re !== -16'sd4096) begin
            n_fail++; $display("FAIL conj_inv: got %0d/%0d expected 4096/-4096", u1_if.Xa_re, u1_if.Xb_re);
        end
        take();
        do_op(16'sd0, 16'sd0, 16'sd0, 16'sd16384, 16'sd0, -16'sd32768, lat);
        n_checks++;
        if (u1_if.Xa_re !== -16'sd8191 || u1_if.Xb_re !== 16'sd8191) begin
            n_fail++; $display("FAIL conj_min_inv: got %0d/%0d expected -8191/8191", u1_if.Xa_re, u1_if.Xb_re);
        end
        n_checks++;
        if (u0_if.Xa_re !== 16'sd8192 || u0_if.Xb_re !== -16'sd8192) begin
            n_fail++; $display("FAIL conj_min_fwd: got %0d/%0d expected 8192/-8192", u0_if.Xa_re, u0_if.Xb_re);
        end
        n_checks++;
        if (u2_if.Xa_re !== 16'sd4096 || u2_if.Xb_re !== -16'sd4096) begin
            n_fail++; $display("FAIL conj_min_scale: got %0d/%0d expected 4096/-4096", u2_if.Xa_re, u2_if.Xb_re);
        end
        take();
    endtask

    task automatic test_backpressure();
        int lat;
        do_op(16'sd4096, 16'sd0, 16'sd16384, 16'sd0, 16'sd32767, 16'sd0, lat);
        xa_re = 16'sh1234; xb_re = -16'sd100; w_re = 16'sd200;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (u0_if.out_valid !== 1'b1 || u0_if.Xa_re !== 16'sd12287 || u0_if.Xb_re !== -16'sd4095 || u0_if.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: got valid=%b Xa_re=%0d Xb_re=%0d in_ready=%b expected 1/12287/-4095/0",
                         i, u0_if.out_valid, u0_if.Xa_re, u0_if.Xb_re, u0_if.in_ready);
            end
        end
        xa_re = 16'sd28672; xa_im = 16'sd0; xb_re = 16'sd32767; xb_im = 16'sd0; w_re = 16'sd32767; w_im = 16'sd0;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (u0_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL simul_in_ready: got %b expected 1", u0_if.in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (u0_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL simul_valid_drop: got %b expected 0", u0_if.out_valid); end
        lat = 0;
        while (u0_if.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (lat != 5) begin n_fail++; $display("FAIL simul_latency: got %0d expected 5", lat); end
        n_checks++;
        if (u0_if.Xa_re !== 16'sd32767 || u0_if.Xb_re !== 16'sd12289) begin
            n_fail++; $display("FAIL simul_result: got %0d/%0d expected 32767/12289", u0_if.Xa_re, u0_if.Xb_re);
        end
        take();
    endtask

    task automatic test_back_to_back();
        int idx[$];
        xa_re = 16'sd4096; xa_im = 16'sd0; xb_re = 16'sd16384; xb_im = 16'sd0; w_re = 16'sd32767; w_im = 16'sd0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (u0_if.out_valid === 1'b1) idx.push_back(k);
        end
        in_valid = 1'b0;
        n_checks++;
        if (idx.size() < 3) begin
            n_fail++; $display("FAIL b2b_count: got %0d results expected at least 3", idx.size());
        end else begin
            n_checks++;
            if (idx[0] != 5 || idx[1] != 11 || idx[2] != 17) begin
                n_fail++; $display("FAIL b2b_spacing: got %0d,%0d,%0d expected 5,11,17", idx[0], idx[1], idx[2]);
            end
        end
        repeat (8) @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_checks++;
        if (u0_if.in_ready !== 1'b1 || u0_if.Xa_re !== 16'sd12287) begin
            n_fail++; $display("FAIL b2b_drain: got in_ready=%b Xa_re=%0d expected 1/12287", u0_if.in_ready, u0_if.Xa_re);
        end
    endtask

    task automatic test_reset_midop();
        logic seen;
        xa_re = 16'sd4096; xa_im = 16'sd0; xb_re = 16'sd16384; xb_im = 16'sd0; w_re = 16'sd32767; w_im = 16'sd0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (u0_if.out_valid !== 1'b0 || u0_if.Xa_re !== 16'sd0 || u0_if.Xb_re !== 16'sd0) begin
            n_fail++; $display("FAIL midop_reset_out: got valid=%b Xa_re=%0d Xb_re=%0d expected 0/0/0",
                               u0_if.out_valid, u0_if.Xa_re, u0_if.Xb_re);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (u0_if.out_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL midop_stale: got stale out_valid expected none"); end
        n_checks++;
        if (u0_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL midop_in_ready: got %b expected 1", u0_if.in_ready); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_imag();
        test_saturation();
        test_conjugate();
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
